// File: rtl/fix_session_engine.sv
// Multi-host FIX session layer: per-host session FSMs, a shared byte-serial MsgType parser,
// heartbeat timers and a round-robin framer that writes Logon/Heartbeat/Logout frames to a FIFO.
module fix_session_engine #(
  parameter int NUM_HOSTS = 4,
  parameter int HOST_W    = $clog2(NUM_HOSTS),
  parameter int HB_CYCLES = 1024,
  parameter int HB_W      = $clog2(HB_CYCLES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 connect_i,
  input  logic [HOST_W-1:0]    connect_to_host_i,
  input  logic                 connected_i,
  input  logic [HOST_W-1:0]    connected_host_addr_i,
  input  logic                 msg_valid_i,
  input  logic [HOST_W-1:0]    msg_host_i,
  input  logic [7:0]           message_i,
  input  logic                 msg_end_i,
  input  logic                 fifo_full_i,
  output logic                 fifo_write_o,
  output logic [7:0]           message_o,
  output logic [NUM_HOSTS-1:0] host_active_o
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_LOGON_WAIT, S_ACTIVE} sess_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_e;

  sess_e                r_sess      [NUM_HOSTS];
  sess_e                w_sessNext  [NUM_HOSTS];
  logic [HB_W-1:0]      r_timer     [NUM_HOSTS];
  logic [HB_W-1:0]      w_timerNext [NUM_HOSTS];
  logic [NUM_HOSTS-1:0] r_pendLogout, r_pendLogon, r_pendHb;
  logic [NUM_HOSTS-1:0] w_setLogout, w_setLogon, w_setHb;
  logic [NUM_HOSTS-1:0] w_clrLogout, w_clrLogon, w_clrHb;
  logic [NUM_HOSTS-1:0] w_anyPend;

  logic              r_inMsg, r_fieldStart, r_typeValid;
  logic [1:0]        r_tagPos;
  logic [7:0]        r_msgType;
  logic [HOST_W-1:0] r_parseHost;
  logic              w_newMsg, w_atFieldStart, w_capture, w_evalValid;
  logic [1:0]        w_tagPos;
  logic [7:0]        w_evalType;

  tx_e               r_txState, w_txNext;
  logic [HOST_W-1:0] r_txHost, r_lastHost, w_selHost, w_rrIdx;
  logic [7:0]        r_txType, w_selType;
  logic [2:0]        r_byteIdx;
  logic              w_found;

  // A host change mid-message is treated as the first byte of a fresh message.
  assign w_newMsg       = !r_inMsg || (msg_host_i != r_parseHost);
  assign w_tagPos       = w_newMsg ? 2'd0 : r_tagPos;
  assign w_atFieldStart = w_newMsg || r_fieldStart;
  assign w_capture      = (w_tagPos == 2'd3);
  assign w_evalValid    = msg_valid_i && msg_end_i && (w_capture || (!w_newMsg && r_typeValid));
  assign w_evalType     = w_capture ? message_i : r_msgType;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inMsg      <= 1'b0;
      r_fieldStart <= 1'b0;
      r_typeValid  <= 1'b0;
      r_tagPos     <= 2'd0;
      r_msgType    <= 8'h00;
      r_parseHost  <= '0;
    end else if (msg_valid_i) begin
      if (msg_end_i) begin
        r_inMsg      <= 1'b0;
        r_fieldStart <= 1'b0;
        r_typeValid  <= 1'b0;
        r_tagPos     <= 2'd0;
      end else begin
        r_inMsg      <= 1'b1;
        r_parseHost  <= msg_host_i;
        r_fieldStart <= (message_i == 8'h01);
        if (w_newMsg) r_typeValid <= 1'b0;
        if (w_capture) begin
          r_msgType   <= message_i;
          r_typeValid <= 1'b1;
          r_tagPos    <= 2'd0;
        end else if (w_atFieldStart && message_i == 8'h33) r_tagPos <= 2'd1;
        else if (w_tagPos == 2'd1 && message_i == 8'h35)   r_tagPos <= 2'd2;
        else if (w_tagPos == 2'd2 && message_i == 8'h3D)   r_tagPos <= 2'd3;
        else                                               r_tagPos <= 2'd0;
      end
    end
  end

  always_comb begin
    w_setLogout = '0;
    w_setLogon  = '0;
    w_setHb     = '0;
    for (int h = 0; h < NUM_HOSTS; h++) begin
      w_sessNext[h]  = r_sess[h];
      w_timerNext[h] = '0;
      case (r_sess[h])
        S_IDLE:
          if (connect_i && connect_to_host_i == HOST_W'(h)) w_sessNext[h] = S_PENDING;
        S_PENDING:
          if (connected_i && connected_host_addr_i == HOST_W'(h)) begin
            w_sessNext[h] = S_LOGON_WAIT;
            w_setLogon[h] = 1'b1;
          end
        S_LOGON_WAIT:
          if (w_evalValid && msg_host_i == HOST_W'(h) && w_evalType == 8'h41) w_sessNext[h] = S_ACTIVE;
        S_ACTIVE:
          if (w_evalValid && msg_host_i == HOST_W'(h)) begin
            if (w_evalType == 8'h35) begin
              w_sessNext[h]  = S_IDLE;
              w_setLogout[h] = 1'b1;
            end else if (w_evalType == 8'h31) w_setHb[h] = 1'b1;
          end
        default: ;
      endcase
      // Timer only counts while the host stays ACTIVE and is silent this cycle.
      if (r_sess[h] == S_ACTIVE && w_sessNext[h] == S_ACTIVE &&
          !(msg_valid_i && msg_host_i == HOST_W'(h))) begin
        if (r_timer[h] == HB_W'(HB_CYCLES-1)) w_setHb[h] = 1'b1;
        else w_timerNext[h] = r_timer[h] + HB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < NUM_HOSTS; h++) begin
        r_sess[h]  <= S_IDLE;
        r_timer[h] <= '0;
      end
      r_pendLogout <= '0;
      r_pendLogon  <= '0;
      r_pendHb     <= '0;
    end else begin
      for (int h = 0; h < NUM_HOSTS; h++) begin
        r_sess[h]  <= w_sessNext[h];
        r_timer[h] <= w_timerNext[h];
      end
      r_pendLogout <= (r_pendLogout & ~w_clrLogout) | w_setLogout;
      r_pendLogon  <= (r_pendLogon & ~w_clrLogon) | w_setLogon;
      r_pendHb     <= ((r_pendHb & ~w_clrHb) | w_setHb) & ~w_setLogout;
    end
  end

  assign w_anyPend = r_pendLogout | r_pendLogon | r_pendHb;

  always_comb begin
    w_found     = 1'b0;
    w_selHost   = '0;
    w_rrIdx     = '0;
    w_selType   = 8'h30;
    w_clrLogout = '0;
    w_clrLogon  = '0;
    w_clrHb     = '0;
    for (int i = 1; i <= NUM_HOSTS; i++) begin
      w_rrIdx = r_lastHost + HOST_W'(i);
      if (!w_found && w_anyPend[w_rrIdx]) begin
        w_found   = 1'b1;
        w_selHost = w_rrIdx;
      end
    end
    if (r_txState == TX_IDLE && w_found) begin
      if (r_pendLogout[w_selHost]) begin
        w_clrLogout[w_selHost] = 1'b1;
        w_selType = 8'h35;
      end else if (r_pendLogon[w_selHost]) begin
        w_clrLogon[w_selHost] = 1'b1;
        w_selType = 8'h41;
      end else begin
        w_clrHb[w_selHost] = 1'b1;
        w_selType = 8'h30;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_txState <= TX_IDLE;
    else     r_txState <= w_txNext;
  end

  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      TX_IDLE: if (w_found) w_txNext = TX_SEND;
      TX_SEND: if (fifo_write_o && r_byteIdx == 3'd6) w_txNext = TX_IDLE;
      default: w_txNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txHost   <= '0;
      r_txType   <= 8'h00;
      r_byteIdx  <= 3'd0;
      r_lastHost <= HOST_W'(NUM_HOSTS-1);
    end else if (r_txState == TX_IDLE && w_found) begin
      r_txHost   <= w_selHost;
      r_txType   <= w_selType;
      r_byteIdx  <= 3'd0;
      r_lastHost <= w_selHost;
    end else if (fifo_write_o) begin
      r_byteIdx <= (r_byteIdx == 3'd6) ? 3'd0 : r_byteIdx + 3'd1;
    end
  end

  // message_o depends only on state and byte index, so it holds steady through a stall.
  always_comb begin
    fifo_write_o = (r_txState == TX_SEND) && !fifo_full_i;
    message_o    = 8'h00;
    if (r_txState == TX_SEND) begin
      case (r_byteIdx)
        3'd0:    message_o = 8'(r_txHost);
        3'd1:    message_o = 8'h33;
        3'd2:    message_o = 8'h35;
        3'd3:    message_o = 8'h3D;
        3'd4:    message_o = r_txType;
        3'd5:    message_o = 8'h01;
        default: message_o = 8'h3B;
      endcase
    end
    for (int h = 0; h < NUM_HOSTS; h++) host_active_o[h] = (r_sess[h] == S_ACTIVE);
  end

endmodule

// File: doc/fix_session_engine.md
# fix_session_engine

Multi-host FIX session layer between the TCP offload engine (TOE) and the outbound byte FIFO. It tracks a per-host session state machine and parses inbound FIX bytes for the MsgType field (tag 35). It generates Logon, Heartbeat and Logout messages as framed byte streams into the FIFO, using round-robin arbitration across hosts and stalling on FIFO-full backpressure. This block is the parametrised multi-host successor of the single-connection fix_engine, and adds heartbeat timers and response generation.

## Interface
- NUM_HOSTS, 4: number of sessions; must be ≥ 2 and a power of two.
- HOST_W, $clog2(NUM_HOSTS): host index width.
- HB_CYCLES, 1024: idle cycles before a heartbeat is sent on an ACTIVE session; must be ≥ 2.
- HB_W, $clog2(HB_CYCLES+1): heartbeat counter width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- connect_i  in  1  application connect request; single-cycle pulse.
- connect_to_host_i  in  HOST_W  target host for connect_i.
- connected_i  in  1  TOE reports TCP connection established; single-cycle pulse.
- connected_host_addr_i  in  HOST_W  host for connected_i.
- msg_valid_i  in  1  inbound byte valid.
- msg_host_i  in  HOST_W  source host of the inbound byte.
- message_i  in  8  inbound FIX byte.
- msg_end_i  in  1  marks the last byte of an inbound message; qualified by msg_valid_i.
- fifo_full_i  in  1  outbound FIFO full.
- fifo_write_o  out  1  write strobe for message_o.
- message_o  out  8  outbound byte.
- host_active_o  out  NUM_HOSTS  one bit per host, high while that host is ACTIVE.

## Operation
- Per-host session states are IDLE, PENDING, LOGON_WAIT and ACTIVE.
  - IDLE→PENDING when connect_i names the host. connect_i on a non-IDLE host is ignored.
  - PENDING→LOGON_WAIT when connected_i names the host; this also sets pend_logon. connected_i in any other state is ignored.
  - LOGON_WAIT→ACTIVE on an inbound message whose type is 'A'.
  - ACTIVE: an inbound type '1' (TestRequest) sets pend_hb. An inbound type '5' sets pend_logout and moves the host to IDLE.
  - Inbound bytes for IDLE or PENDING hosts are discarded.
- Parser (one shared instance, byte-serial): tracks field start, which is the first byte of a message or the byte after SOH (8'h01).
  - The sequence '3','5','=' at field start arms capture; the next byte is latched as the MsgType.
  - At msg_end_i the latched type is evaluated for msg_host_i, then the parser clears.
  - A message with no tag 35 has no effect.
  - msg_host_i must stay constant within a message. A change mid-message is unsupported; the parser restarts on the new host.
- Heartbeat timer (one per host) runs only in ACTIVE.
  - It reloads to 0 on any valid inbound byte for that host and on entering ACTIVE.
  - On reaching HB_CYCLES-1 it sets pend_hb and wraps to 0.
- Pending flags are per host: pend_logout, pend_logon, pend_hb.
  - Setting a flag that is already set coalesces; no second message is sent.
  - A flag clears when its message is selected for transmission.
  - A set on the same edge as the clear re-arms the flag.
  - pend_logout clears pend_hb for the same host.
- Transmitter states are TX_IDLE and TX_SEND.
  - In TX_IDLE it picks the next host with any pending flag, round-robin starting after the last served host.
  - Within a host, priority is logout > logon > hb.
  - Frame is 7 bytes: {host index zero-extended}, '3', '5', '=', type ('5'/'A'/'0'), 8'h01, 8'h3B.
  - The byte index advances only when fifo_write_o is high. After byte 6 the transmitter returns to TX_IDLE.

## Timing
- Reset values: all hosts IDLE, flags 0, timers 0, TX_IDLE, round-robin pointer at host NUM_HOSTS-1 (so host 0 is served first), fifo_write_o=0, message_o=8'h00, host_active_o=0.
- fifo_write_o = TX_SEND && !fifo_full_i, combinational from state and fifo_full_i.
- message_o is driven from the byte index and is stable while stalled.
- Latency:
  - A pending flag is set on the edge that samples the triggering event.
  - The transmitter latches its selection on the next edge.
  - First fifo_write_o is high in the following cycle.
  - From an event sampled at edge E0, the first write is sampled at edge E2, provided the FIFO is not full and the transmitter is idle.
- Back-to-back frames: one TX_IDLE cycle between frames.
- Minimum frame time is 7 write cycles. fifo_full_i stalls for its full duration with no byte loss or duplication.
- connect_i and connected_i for different hosts in the same cycle are both applied. connected_i for a host on the same edge as its IDLE→PENDING transition is ignored.
- An asynchronous reset mid-frame abandons the frame. fifo_write_o drops immediately.

## Test plan
- Connect host 1, connected_i on host 1 → frame 01 33 35 3D 41 01 3B is written, and host_active_o stays 0. Inbound "35=A|" with msg_end on host 1 → host_active_o=4'b0010.
- Host 1 ACTIVE, inbound "8=FIX.4.2|35=1|10=000|" → frame 01 33 35 3D 30 01 3B. First write is sampled 2 edges after msg_end_i.
- HB_CYCLES=16, host 2 ACTIVE with no traffic → heartbeat frame for host 2 every 16 cycles. Inbound bytes on host 2 postpone it.
- Hosts 0 and 3 ACTIVE with simultaneous timer expiry, fifo_full_i toggling every 3 cycles → host 0 frame then host 3 frame, each 7 bytes exactly, with no gaps in content.
- Host 0 ACTIVE, inbound "35=5|" → logout frame 00 33 35 3D 35 01 3B, host_active_o[0]=0, and later inbound "35=1|" on host 0 produces no output.
- Assert rst during byte 3 of a frame → fifo_write_o=0 at once, all outputs at reset values, and no frame resumes after release.
